rr_mux_arbiter_8: RTL and testbench

- Round-robin arbiter and sequencer for the shared 8:1 single-bit mux datapath.
- Eight requesters each drive one data bit into `in[7:0]`; the arbiter picks one owner and drives the mux select.
- It registers the selected bit onto a shared output with a valid flag.
- Bounded hold time per grant prevents one requester starving the rest.

---
 rtl/rr_mux_arbiter_8.sv | 87 ++++++++
 tb/tb_rr_mux_arbiter_8.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_8.sv
// rr_mux_arbiter_8: round-robin arbiter driving a shared 8:1 single-bit mux with bounded hold
module rr_mux_arbiter_8 #(
    parameter int MAX_HOLD = 4,
    parameter int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       out,
    output logic       valid,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [HC_W-1:0] HMAX = HC_W'(MAX_HOLD);
    state_t state, nxt_state;
    logic [7:0] nxt_gnt;
    logic [2:0] nxt_sel, ptr, nxt_ptr, p_idle, p_next;
    logic [HC_W-1:0] hold_cnt, nxt_hold;
    // descending scan so the smallest offset from s is the one that sticks
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] s);
        logic [2:0] p, idx;
        p = s;
        for (int k = 7; k >= 0; k--) begin
            idx = s + 3'(k);
            if (r[idx]) p = idx;
        end
        return p;
    endfunction
    assign p_idle = pick(req, ptr);
    assign p_next = pick(req, sel + 3'd1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            out      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state    <= nxt_state;
            gnt      <= nxt_gnt;
            sel      <= nxt_sel;
            ptr      <= nxt_ptr;
            hold_cnt <= nxt_hold;
            out      <= (|gnt) ? in[sel] : out;
            valid    <= |gnt;
        end
    end
    always_comb begin
        nxt_state = state;
        nxt_gnt   = gnt;
        nxt_sel   = sel;
        nxt_ptr   = ptr;
        nxt_hold  = hold_cnt;
        if (state == IDLE) begin
            if (|req) begin
                nxt_state = GRANT;
                nxt_sel   = p_idle;
                nxt_gnt   = 8'd1 << p_idle;
                nxt_hold  = HC_W'(1);
            end
        end else if (!req[sel]) begin
            nxt_ptr = sel + 3'd1;
            if (|req) begin
                nxt_sel  = p_next;
                nxt_gnt  = 8'd1 << p_next;
                nxt_hold = HC_W'(1);
            end else begin
                nxt_state = IDLE;
                nxt_gnt   = '0;
                nxt_hold  = '0;
            end
        end else if (MAX_HOLD != 0 && hold_cnt == HMAX && |(req & ~gnt)) begin
            nxt_ptr  = sel + 3'd1;
            nxt_sel  = p_next;
            nxt_gnt  = 8'd1 << p_next;
            nxt_hold = HC_W'(1);
        end else begin
            nxt_hold = (hold_cnt == HMAX) ? hold_cnt : hold_cnt + 1'b1;
        end
    end
    always_comb busy = (state == GRANT);
endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// tb_rr_mux_arbiter_8: vector table, directed sequences and random run against a behavioural model
module tb_rr_mux_arbiter_8;
    localparam int MAXH = 4;
    logic clk = 0, rst_n = 0;
    logic [7:0] req = 0, in = 0, gnt;
    logic [2:0] sel;
    logic out, valid, busy;
    int n_vec = 0, n_bad = 0;
    bit use_model = 0;
    // model: owner index (-1 idle), pointer and cycles held so far
    int m_owner = -1, m_ptr = 0, m_held = 0, m_sel = 0;
    logic m_out = 0, m_valid = 0;

    rr_mux_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in(in),
        .gnt(gnt), .sel(sel), .out(out), .valid(valid), .busy(busy)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] in;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       out;
        logic       valid;
        logic       busy;
    } vec_t;

    function automatic int mpick(input logic [7:0] r, input int s);
        for (int k = 0; k < 8; k++) if (r[(s + k) % 8]) return (s + k) % 8;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_out = 0; m_valid = 0;
            return;
        end
        if (m_owner >= 0) m_out = in[m_sel];
        m_valid = (m_owner >= 0);
        if (m_owner < 0) begin
            if (req != 0) begin m_owner = mpick(req, m_ptr); m_held = 1; end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % 8;
            if (req != 0) begin m_owner = mpick(req, m_ptr); m_held = 1; end
            else begin m_owner = -1; m_held = 0; end
        end else if (MAXH != 0 && m_held >= MAXH && (req & ~(8'd1 << m_owner)) != 0) begin
            m_ptr = (m_owner + 1) % 8;
            m_owner = mpick(req, m_ptr);
            m_held = 1;
        end else m_held++;
        if (m_owner >= 0) m_sel = m_owner;
    endtask

    task automatic step();
        logic [7:0] eg;
        @(posedge clk);
        #1;
        model_edge();
        if (use_model) begin
            eg = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
            check("model {gnt,sel,out,valid,busy}", {gnt, sel, out, valid, busy},
                  {eg, 3'(m_sel), m_out, m_valid, m_owner >= 0});
            check("gnt onehot0/gnt[sel]", {$onehot0(gnt), (gnt == 0) || gnt[sel]}, 2'b11);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; req = 0; step(); rst_n = 1;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0};
        tbl[1] = '{1, 8'h05, 8'hFF, 8'h01, 3'd0, 0, 0, 1};
        tbl[2] = '{1, 8'h05, 8'hFF, 8'h01, 3'd0, 1, 1, 1};
        tbl[3] = '{1, 8'h04, 8'hFF, 8'h04, 3'd2, 1, 1, 1};
        tbl[4] = '{1, 8'h04, 8'h00, 8'h04, 3'd2, 0, 1, 1};
        tbl[5] = '{1, 8'h00, 8'h00, 8'h00, 3'd2, 0, 1, 0};
        tbl[6] = '{1, 8'h00, 8'h00, 8'h00, 3'd2, 0, 0, 0};
        tbl[7] = '{1, 8'h08, 8'hFF, 8'h08, 3'd3, 0, 0, 1};
        tbl[8] = '{1, 8'h00, 8'hFF, 8'h00, 3'd3, 1, 1, 0};
        tbl[9] = '{1, 8'h00, 8'hFF, 8'h00, 3'd3, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            rst_n = tbl[i].rst_n; req = tbl[i].req; in = tbl[i].in;
            step();
            check($sformatf("table[%0d]", i), {gnt, sel, out, valid, busy},
                  {tbl[i].gnt, tbl[i].sel, tbl[i].out, tbl[i].valid, tbl[i].busy});
        end
        use_model = 1;
        // all requesting: each owner holds exactly MAXH cycles, 0..7 then wrap
        do_reset();
        req = 8'hFF;
        for (int c = 1; c <= 40; c++) begin
            in = c[0] ? 8'hFF : 8'h00;
            step();
            if (c == 1) check("rotate sel@1", sel, 0);
            if (c == 5) check("rotate sel@5", sel, 1);
            if (c == 29) check("rotate sel@29", sel, 7);
            if (c == 33) check("rotate wrap sel@33", sel, 0);
        end
        // lone requester keeps the grant indefinitely
        do_reset();
        req = 8'h80; in = 8'h80;
        for (int c = 0; c < 20; c++) step();
        check("lone owner gnt", gnt, 8'h80);
        req = 0; step();
        check("lone drop gnt", gnt, 0);
        step();
        check("lone drop valid/busy", {valid, busy}, 2'b00);
        // fairness: after owner 6 releases, scan wraps from 7
        do_reset();
        req = 8'h40; step(); step();
        req = 8'h03; step();
        check("fair wrap to 0", gnt, 8'h01);
        req = 8'h43;
        for (int c = 0; c < 12; c++) step();
        // reset while granted
        do_reset();
        req = 8'h10; in = 8'hFF; step(); step();
        check("pre-reset gnt", gnt, 8'h10);
        rst_n = 0; step();
        check("mid-grant reset", {gnt, sel, out, valid, busy}, 14'd0);
        rst_n = 1; step();
        check("regrant after reset", gnt, 8'h10);
        // random traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(3) == 0) req = 8'($urandom);
            in = 8'($urandom);
            rst_n = ($urandom_range(199) != 0);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
